// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared definitions for the AES input loader: block and word
//            widths, default timing parameters, loader FSM state encoding
//            and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLK_W       = 128;
    localparam int AES_WORD_W      = 32;
    localparam int AES_WORDS       = AES_BLK_W / AES_WORD_W;
    localparam int DEF_TIMEOUT_CYC = 64;
    localparam int DEF_GAP_CYC     = 2;

    // Loader FSM states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KEY  = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_RUN       = 3'd3,
        ST_GAP       = 3'd4
    } ldr_state_t;

    // Width of a counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : aes_word_packer
// Purpose  : Assembles four 32-bit words into a 128-bit block. Slot 0 is the
//            most significant word. Keeps its own 2-bit word count.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            i_clr        - zero the block and the count
//            i_wr         - write i_word at the current slot
//            i_first      - with i_wr: write slot 0 and restart the count
//            i_word       - word to store
//            o_blk        - assembled block
//            o_cnt        - number of words held (wraps to 0 after the 4th)
// Revision : 1.0 - initial release
// ============================================================================
module aes_word_packer
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_wr,
    input  logic                  i_first,
    input  logic [AES_WORD_W-1:0] i_word,
    output logic [AES_BLK_W-1:0]  o_blk,
    output logic [1:0]            o_cnt
);

    logic [AES_BLK_W-1:0] r_blk;
    logic [1:0]           r_cnt;
    logic [1:0]           w_slot;

    // A group start always lands in slot 0, whatever the count holds.
    assign w_slot = i_first ? 2'd0 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_blk <= '0;
            r_cnt <= '0;
        end else if (i_wr) begin
            for (int i = 0; i < AES_WORDS; i++) begin
                if (w_slot == 2'(i)) begin
                    r_blk[(AES_WORDS-1-i)*AES_WORD_W +: AES_WORD_W] <= i_word;
                end
            end
            r_cnt <= w_slot + 2'd1;
        end
    end

    assign o_blk = r_blk;
    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/aes_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_in_loader
// Purpose  : Collects 32-bit key / plaintext words from an upstream
//            valid/ready stream into 128-bit registers, starts the AES core,
//            waits (bounded) for completion and enforces an idle gap between
//            blocks. A loaded key is kept so later blocks may send data only.
// Ports    : AES_clk, AES_rst_n           - clock, async active-low reset
//            s_data, s_is_key, s_valid    - upstream word stream
//            s_ready                      - loader accepts a word
//            AES_en                       - core enable, high while running
//            AES_data_in, AES_key_in      - assembled plaintext / key
//            AES_data_out_valid           - completion strobe from the core
//            busy                         - running or in the inter-block gap
//            done, err, timeout           - one-cycle status pulses
// Revision : 1.0 - initial release
// ============================================================================
module aes_in_loader
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC
) (
    input  logic                  AES_clk,
    input  logic                  AES_rst_n,
    input  logic [AES_WORD_W-1:0] s_data,
    input  logic                  s_is_key,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  AES_en,
    output logic [AES_BLK_W-1:0]  AES_data_in,
    output logic [AES_BLK_W-1:0]  AES_key_in,
    input  logic                  AES_data_out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  timeout
);

    localparam int                 c_run_w    = cnt_w(TIMEOUT_CYC);
    localparam int                 c_gap_w    = cnt_w(GAP_CYC);
    localparam logic [c_run_w-1:0] c_run_last = c_run_w'(TIMEOUT_CYC - 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYC - 1);

    ldr_state_t         r_state, w_state_nxt;
    logic               r_key_ok, w_key_ok_nxt;
    logic [c_run_w-1:0] r_run_cnt, w_run_nxt;
    logic [c_gap_w-1:0] r_gap_cnt, w_gap_nxt;
    logic               r_en, r_busy, r_ready;
    logic               r_done, r_err, r_timeout;
    logic               w_done_nxt, w_err_nxt, w_to_nxt;

    logic               w_key_wr, w_key_first, w_key_clr;
    logic               w_data_wr, w_data_first, w_data_clr;
    logic [1:0]         w_key_cnt, w_data_cnt, w_wcnt;
    logic               w_xfer;

    assign w_xfer = s_valid & r_ready;
    // The word counter of interest is the one of the block being loaded.
    assign w_wcnt = (r_state == ST_LOAD_KEY) ? w_key_cnt : w_data_cnt;

    aes_word_packer u_key_packer (
        .clk     (AES_clk),
        .rst_n   (AES_rst_n),
        .i_clr   (w_key_clr),
        .i_wr    (w_key_wr),
        .i_first (w_key_first),
        .i_word  (s_data),
        .o_blk   (AES_key_in),
        .o_cnt   (w_key_cnt)
    );

    aes_word_packer u_data_packer (
        .clk     (AES_clk),
        .rst_n   (AES_rst_n),
        .i_clr   (w_data_clr),
        .i_wr    (w_data_wr),
        .i_first (w_data_first),
        .i_word  (s_data),
        .o_blk   (AES_data_in),
        .o_cnt   (w_data_cnt)
    );

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_state   <= ST_IDLE;
            r_key_ok  <= 1'b0;
            r_run_cnt <= '0;
            r_gap_cnt <= '0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_key_ok  <= w_key_ok_nxt;
            r_run_cnt <= w_run_nxt;
            r_gap_cnt <= w_gap_nxt;
            // Status outputs follow the next state so they line up with it.
            r_en      <= (w_state_nxt == ST_RUN);
            r_busy    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_GAP);
            r_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD_KEY) ||
                         (w_state_nxt == ST_LOAD_DATA);
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_timeout <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_key_ok_nxt = r_key_ok;
        w_run_nxt    = r_run_cnt;
        w_gap_nxt    = r_gap_cnt;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_to_nxt     = 1'b0;
        w_key_wr     = 1'b0;
        w_key_first  = 1'b0;
        w_key_clr    = 1'b0;
        w_data_wr    = 1'b0;
        w_data_first = 1'b0;
        w_data_clr   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_run_nxt = '0;
                w_gap_nxt = '0;
                if (w_xfer) begin
                    if (s_is_key) begin
                        w_key_wr     = 1'b1;
                        w_key_first  = 1'b1;
                        w_key_ok_nxt = 1'b0;
                        w_state_nxt  = ST_LOAD_KEY;
                    end else if (r_key_ok) begin
                        w_data_wr    = 1'b1;
                        w_data_first = 1'b1;
                        w_state_nxt  = ST_LOAD_DATA;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            ST_LOAD_KEY: begin
                if (w_xfer) begin
                    if (s_is_key) begin
                        w_key_wr = 1'b1;
                        if (w_wcnt == 2'd3) begin
                            w_key_ok_nxt = 1'b1;
                            // Data must start at slot 0 after a fresh key.
                            w_data_clr   = 1'b1;
                            w_state_nxt  = ST_LOAD_DATA;
                        end
                    end else begin
                        w_err_nxt    = 1'b1;
                        w_key_clr    = 1'b1;
                        w_key_ok_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end

            ST_LOAD_DATA: begin
                if (w_xfer) begin
                    if (!s_is_key) begin
                        w_data_wr = 1'b1;
                        if (w_wcnt == 2'd3) begin
                            w_run_nxt   = '0;
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        // Partial data is dropped; a completed key survives.
                        w_err_nxt   = 1'b1;
                        w_data_clr  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_RUN: begin
                // Completion wins over a simultaneous expiry.
                if (AES_data_out_valid) begin
                    w_done_nxt  = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else if (r_run_cnt == c_run_last) begin
                    w_to_nxt    = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_run_nxt = r_run_cnt + c_run_w'(1);
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + c_gap_w'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_ready = r_ready;
    assign AES_en  = r_en;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_aes_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_in_loader
// Purpose  : Self-checking bench for aes_in_loader. Expected key/data blocks
//            are queued when a block is sent and popped when the core is
//            enabled.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_in_loader;

    logic         AES_clk = 1'b0;
    logic         AES_rst_n;
    logic [31:0]  s_data;
    logic         s_is_key;
    logic         s_valid;
    logic         s_ready;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic         AES_data_out_valid;
    logic         busy;
    logic         done;
    logic         err;
    logic         timeout;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] data;
    } blk_t;

    blk_t sb_q[$];
    blk_t exp_b;
    int   total = 0;
    int   bad   = 0;

    aes_in_loader #(
        .TIMEOUT_CYC (64),
        .GAP_CYC     (2)
    ) dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .s_data             (s_data),
        .s_is_key           (s_is_key),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .AES_en             (AES_en),
        .AES_data_in        (AES_data_in),
        .AES_key_in         (AES_key_in),
        .AES_data_out_valid (AES_data_out_valid),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .timeout            (timeout)
    );

    always #5 AES_clk = ~AES_clk;

    // Offer one word; returns 1 time unit after the capturing edge.
    task automatic send_word(input logic [31:0] d, input logic k);
        int n;
        n = 0;
        @(negedge AES_clk);
        while (!s_ready && n < 200) begin
            @(negedge AES_clk);
            n++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: s_ready=%b after %0d cycles, required 1", s_ready, n);
        end
        s_data   = d;
        s_is_key = k;
        s_valid  = 1'b1;
        @(posedge AES_clk);
        #1;
        s_valid  = 1'b0;
    endtask

    task automatic test_reset;
        AES_rst_n = 1'b0;
        s_data = '0; s_is_key = 1'b0; s_valid = 1'b0; AES_data_out_valid = 1'b0;
        repeat (3) @(posedge AES_clk);
        #1;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
        total++;
        if ({AES_en, busy, done, err, timeout} !== 5'b0) begin
            bad++; $display("FAIL rst_flags: en/busy/done/err/to=%b want 00000", {AES_en, busy, done, err, timeout});
        end
        total++;
        if (AES_data_in !== 128'h0 || AES_key_in !== 128'h0) begin
            bad++; $display("FAIL rst_regs: data=%h key=%h want 0", AES_data_in, AES_key_in);
        end
        @(negedge AES_clk);
        AES_rst_n = 1'b1;
        @(posedge AES_clk);
        #1;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_first_data_err;
        send_word(32'h12345678, 1'b0);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL nokey_err: got %b want 1", err); end
        total++;
        if (s_ready !== 1'b1 || AES_en !== 1'b0) begin
            bad++; $display("FAIL nokey_state: ready=%b en=%b want 1 0", s_ready, AES_en);
        end
        @(posedge AES_clk);
        #1;
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL nokey_pulse: err=%b want 0", err); end
    endtask

    task automatic test_basic;
        logic [31:0] k [4];
        logic [31:0] d [4];
        int g;
        k = '{32'haa2bdb40, 32'hbff6a5e8, 32'hcaa9ba3e, 32'hbc1e2acc};
        d = '{32'h00000021, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) send_word(k[i], 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                total++;
                if (AES_en !== 1'b0) begin bad++; $display("FAIL basic_en_early: en=%b want 0", AES_en); end
                sb_q.push_back('{key: 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                                 data: 128'h00000021_00000000_00000000_00000000});
            end
            send_word(d[i], 1'b0);
        end
        total++;
        if (AES_en !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            bad++; $display("FAIL basic_run: en/busy/ready=%b%b%b want 110", AES_en, busy, s_ready);
        end
        exp_b = sb_q.pop_front();
        total++;
        if (AES_key_in !== exp_b.key) begin bad++; $display("FAIL basic_key: got %h want %h", AES_key_in, exp_b.key); end
        total++;
        if (AES_data_in !== exp_b.data) begin bad++; $display("FAIL basic_data: got %h want %h", AES_data_in, exp_b.data); end
        repeat (3) begin
            @(posedge AES_clk);
            #1;
            total++;
            if (AES_en !== 1'b1 || AES_data_in !== exp_b.data || AES_key_in !== exp_b.key) begin
                bad++; $display("FAIL basic_hold: en=%b data=%h key=%h", AES_en, AES_data_in, AES_key_in);
            end
        end
        @(negedge AES_clk);
        AES_data_out_valid = 1'b1;
        @(posedge AES_clk);
        #1;
        AES_data_out_valid = 1'b0;
        total++;
        if (done !== 1'b1 || AES_en !== 1'b0 || timeout !== 1'b0) begin
            bad++; $display("FAIL basic_done: done/en/to=%b%b%b want 100", done, AES_en, timeout);
        end
        g = 0;
        for (int n = 0; n < 10; n++) begin
            if (!(busy && !AES_en)) break;
            g++;
            total++;
            if (AES_data_in !== exp_b.data || AES_key_in !== exp_b.key) begin
                bad++; $display("FAIL basic_gap_hold: data=%h key=%h", AES_data_in, AES_key_in);
            end
            @(posedge AES_clk);
            #1;
        end
        total++;
        if (g != 2 || s_ready !== 1'b1) begin
            bad++; $display("FAIL basic_gap: gap=%0d ready=%b want 2 1", g, s_ready);
        end
    endtask

    task automatic test_data_only;
        logic [31:0] d [4];
        d = '{32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681};
        // A completion strobe while idle must do nothing.
        @(negedge AES_clk);
        AES_data_out_valid = 1'b1;
        @(posedge AES_clk);
        #1;
        AES_data_out_valid = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL idle_valid: done/busy/ready=%b%b%b want 001", done, busy, s_ready);
        end
        sb_q.push_back('{key: 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
                         data: 128'ha6f2daeb_140fa720_529e75d5_21cbc681});
        for (int i = 0; i < 4; i++) send_word(d[i], 1'b0);
        exp_b = sb_q.pop_front();
        total++;
        if (AES_en !== 1'b1 || AES_key_in !== exp_b.key || AES_data_in !== exp_b.data) begin
            bad++; $display("FAIL donly_run: en=%b key=%h data=%h want 1 %h %h",
                            AES_en, AES_key_in, AES_data_in, exp_b.key, exp_b.data);
        end
        @(negedge AES_clk);
        AES_data_out_valid = 1'b1;
        @(posedge AES_clk);
        #1;
        AES_data_out_valid = 1'b0;
        total++;
        if (done !== 1'b1 || AES_en !== 1'b0) begin
            bad++; $display("FAIL donly_done: done/en=%b%b want 10", done, AES_en);
        end
        repeat (2) @(posedge AES_clk);
        #1;
    endtask

    task automatic test_partial_key;
        int e;
        send_word(32'h11111111, 1'b1);
        send_word(32'h22222222, 1'b1);
        send_word(32'h33333333, 1'b0);
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL pkey_err: err/busy/ready=%b%b%b want 101", err, busy, s_ready);
        end
        e = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(32'h40 + i, 1'b0);
            if (err === 1'b1) e++;
        end
        total++;
        if (e != 4 || AES_en !== 1'b0) begin
            bad++; $display("FAIL pkey_reject: errs=%0d en=%b want 4 0", e, AES_en);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] k [4];
        logic [31:0] d [4];
        int n;
        k = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        d = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98};
        for (int i = 0; i < 4; i++) send_word(k[i], 1'b1);
        sb_q.push_back('{key: 128'h00010203_04050607_08090a0b_0c0d0e0f,
                         data: 128'hdeadbeef_01234567_89abcdef_fedcba98});
        for (int i = 0; i < 4; i++) send_word(d[i], 1'b0);
        exp_b = sb_q.pop_front();
        total++;
        if (AES_key_in !== exp_b.key || AES_data_in !== exp_b.data) begin
            bad++; $display("FAIL to_blk: key=%h data=%h want %h %h", AES_key_in, AES_data_in, exp_b.key, exp_b.data);
        end
        n = 0;
        while (n < 200) begin
            @(posedge AES_clk);
            #1;
            n++;
            if (timeout === 1'b1) break;
        end
        total++;
        if (n != 64 || AES_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL to_pulse: cycles=%0d en=%b done=%b busy=%b want 64 0 0 1", n, AES_en, done, busy);
        end
        @(posedge AES_clk);
        #1;
        total++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            bad++; $display("FAIL to_gap1: busy=%b to=%b want 1 0", busy, timeout);
        end
        @(posedge AES_clk);
        #1;
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL to_gap_end: busy=%b ready=%b want 0 1", busy, s_ready);
        end
        // Completion on the very last run cycle takes priority over expiry.
        sb_q.push_back('{key: 128'h00010203_04050607_08090a0b_0c0d0e0f,
                         data: 128'h0000000a_0000000b_0000000c_0000000d});
        for (int i = 0; i < 4; i++) send_word(32'ha + i, 1'b0);
        exp_b = sb_q.pop_front();
        total++;
        if (AES_data_in !== exp_b.data || AES_key_in !== exp_b.key) begin
            bad++; $display("FAIL edge_blk: data=%h key=%h want %h %h", AES_data_in, AES_key_in, exp_b.data, exp_b.key);
        end
        repeat (63) @(posedge AES_clk);
        @(negedge AES_clk);
        total++;
        if (AES_en !== 1'b1) begin bad++; $display("FAIL edge_en: en=%b want 1 on last run cycle", AES_en); end
        AES_data_out_valid = 1'b1;
        @(posedge AES_clk);
        #1;
        AES_data_out_valid = 1'b0;
        total++;
        if (done !== 1'b1 || timeout !== 1'b0 || AES_en !== 1'b0) begin
            bad++; $display("FAIL edge_done: done/to/en=%b%b%b want 100", done, timeout, AES_en);
        end
        repeat (2) @(posedge AES_clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        sb_q.push_back('{key: 128'h00010203_04050607_08090a0b_0c0d0e0f,
                         data: 128'h55555555_66666666_77777777_88888888});
        send_word(32'h55555555, 1'b0);
        send_word(32'h66666666, 1'b0);
        send_word(32'h77777777, 1'b0);
        send_word(32'h88888888, 1'b0);
        exp_b = sb_q.pop_front();
        total++;
        if (AES_en !== 1'b1 || AES_data_in !== exp_b.data) begin
            bad++; $display("FAIL mrst_run: en=%b data=%h want 1 %h", AES_en, AES_data_in, exp_b.data);
        end
        repeat (2) @(posedge AES_clk);
        #2;
        AES_rst_n = 1'b0;
        #1;
        total++;
        if (AES_en !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL mrst_async: en/busy/ready=%b%b%b want 000", AES_en, busy, s_ready);
        end
        total++;
        if (AES_data_in !== 128'h0 || AES_key_in !== 128'h0) begin
            bad++; $display("FAIL mrst_regs: data=%h key=%h want 0", AES_data_in, AES_key_in);
        end
        repeat (2) @(posedge AES_clk);
        #1;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL mrst_hold: ready=%b want 0", s_ready); end
        @(negedge AES_clk);
        AES_rst_n = 1'b1;
        @(posedge AES_clk);
        #1;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL mrst_rel: ready=%b want 1", s_ready); end
        send_word(32'h99999999, 1'b0);
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL mrst_needkey: err=%b busy=%b want 1 0", err, busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_first_data_err;
        test_basic;
        test_data_only;
        test_partial_key;
        test_timeout;
        test_reset_mid_run;
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_empty: %0d entries left, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
